// File: rtl/weight_buffer_ctrl_if.sv
// Handshake bundle between the weight-buffer controller, the weight FIFO and
// the systolic-array compute side. The master drives requests; the slave is the controller.
interface weight_buffer_ctrl_if #(
    parameter int TILE_ROWS  = 32,
    parameter int NUM_BUFS   = 2,
    parameter int TILE_CNT_W = 16
);
    localparam int BUF_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int ROW_W = $clog2(TILE_ROWS);
    localparam int RES_W = $clog2(NUM_BUFS + 1);

    logic                  instruction_i;
    logic [TILE_CNT_W-1:0] num_tiles_i;
    logic                  weight_fifo_valid_output;
    logic                  next_weight_tile_i;
    logic                  done_i;

    logic                  load_weights_o;
    logic [BUF_W-1:0]      wr_buf_o;
    logic [BUF_W-1:0]      rd_buf_o;
    logic [ROW_W-1:0]      row_cntr_o;
    logic [RES_W-1:0]      tiles_resident_o;
    logic                  compute_weights_rdy_o;
    logic                  compute_weights_buffered_o;
    logic                  busy_o;
    logic                  job_done_o;
    logic                  underflow_o;

    modport master (
        output instruction_i, num_tiles_i, weight_fifo_valid_output,
               next_weight_tile_i, done_i,
        input  load_weights_o, wr_buf_o, rd_buf_o, row_cntr_o, tiles_resident_o,
               compute_weights_rdy_o, compute_weights_buffered_o, busy_o,
               job_done_o, underflow_o
    );

    modport slave (
        input  instruction_i, num_tiles_i, weight_fifo_valid_output,
               next_weight_tile_i, done_i,
        output load_weights_o, wr_buf_o, rd_buf_o, row_cntr_o, tiles_resident_o,
               compute_weights_rdy_o, compute_weights_buffered_o, busy_o,
               job_done_o, underflow_o
    );
endinterface

// File: rtl/weight_buffer_ctrl.sv
// N-deep weight-tile ring buffer controller: loads tiles row by row from the
// weight FIFO, tracks resident tiles and a per-instruction tile budget.
module weight_buffer_ctrl #(
    parameter int TILE_ROWS  = 32,
    parameter int NUM_BUFS   = 2,
    parameter int TILE_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    weight_buffer_ctrl_if.slave  bus
);
    localparam int BUF_W = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;
    localparam int ROW_W = $clog2(TILE_ROWS);
    localparam int RES_W = $clog2(NUM_BUFS + 1);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(TILE_ROWS - 1);
    localparam logic [BUF_W-1:0] LAST_BUF = BUF_W'(NUM_BUFS - 1);
    localparam logic [RES_W-1:0] FULL     = RES_W'(NUM_BUFS);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_FULL, DRAIN} state_t;

    state_t                state;
    logic [TILE_CNT_W-1:0] budget;
    logic [TILE_CNT_W-1:0] tiles_loaded;
    logic [TILE_CNT_W-1:0] tiles_released;
    logic [ROW_W-1:0]      row_cntr;
    logic [BUF_W-1:0]      wr_buf;
    logic [BUF_W-1:0]      rd_buf;
    logic [RES_W-1:0]      resident;
    logic                  rdy;
    logic                  buffered;
    logic                  busy;
    logic                  job_done;
    logic                  underflow;

    logic                  transfer;
    logic                  tile_done;
    logic                  no_tile;
    logic                  release_ok;
    logic [RES_W-1:0]      resident_next;
    logic [TILE_CNT_W-1:0] loaded_next;
    logic [TILE_CNT_W-1:0] released_next;

    function automatic logic [BUF_W-1:0] next_buf(input logic [BUF_W-1:0] b);
        return (b == LAST_BUF) ? '0 : b + BUF_W'(1);
    endfunction

    assign transfer      = (state == LOAD) && bus.weight_fifo_valid_output;
    assign tile_done     = transfer && (row_cntr == LAST_ROW);
    assign no_tile       = (resident == '0);
    assign release_ok    = bus.next_weight_tile_i && !no_tile && (state != IDLE);
    // A completion and a release in the same cycle cancel in the resident count.
    assign resident_next = resident + RES_W'(tile_done) - RES_W'(release_ok);
    assign loaded_next   = tiles_loaded + TILE_CNT_W'(tile_done);
    assign released_next = tiles_released + TILE_CNT_W'(release_ok);

    // NOTE: all state below updates with non-blocking assignments so every
    // branch sees the pre-edge values and the ordering of statements is irrelevant.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state          <= IDLE;
            budget         <= '0;
            tiles_loaded   <= '0;
            tiles_released <= '0;
            row_cntr       <= '0;
            wr_buf         <= '0;
            rd_buf         <= '0;
            resident       <= '0;
            rdy            <= 1'b0;
            buffered       <= 1'b0;
            busy           <= 1'b0;
            job_done       <= 1'b0;
            underflow      <= 1'b0;
        end else begin
            job_done <= 1'b0;
            if (bus.done_i) begin
                // Abort: any partial tile is dropped, underflow history is kept.
                state          <= IDLE;
                tiles_loaded   <= '0;
                tiles_released <= '0;
                row_cntr       <= '0;
                wr_buf         <= '0;
                rd_buf         <= '0;
                resident       <= '0;
                rdy            <= 1'b0;
                buffered       <= 1'b0;
                busy           <= 1'b0;
            end else if (state == IDLE) begin
                if (bus.instruction_i) begin
                    budget         <= bus.num_tiles_i;
                    tiles_loaded   <= '0;
                    tiles_released <= '0;
                    row_cntr       <= '0;
                    wr_buf         <= '0;
                    rd_buf         <= '0;
                    resident       <= '0;
                    underflow      <= 1'b0;
                    if (bus.num_tiles_i != '0) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end else begin
                        job_done <= 1'b1;
                    end
                end else if (bus.next_weight_tile_i) begin
                    underflow <= 1'b1;
                end
            end else begin
                if (transfer) row_cntr <= tile_done ? '0 : row_cntr + ROW_W'(1);
                if (tile_done) wr_buf <= next_buf(wr_buf);
                if (release_ok) rd_buf <= next_buf(rd_buf);
                if (bus.next_weight_tile_i && no_tile) underflow <= 1'b1;
                tiles_loaded   <= loaded_next;
                tiles_released <= released_next;
                resident       <= resident_next;
                rdy            <= (resident_next != '0);
                buffered       <= (resident_next == FULL);

                case (state)
                    LOAD: begin
                        if (tile_done) begin
                            if (loaded_next == budget)       state <= DRAIN;
                            else if (resident_next == FULL)  state <= WAIT_FULL;
                        end
                    end
                    WAIT_FULL: begin
                        if (release_ok) state <= LOAD;
                    end
                    DRAIN: begin
                        if (released_next == budget) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            job_done <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // NOTE: the pop enable depends on the state register only, never on FIFO
    // valid, so no combinational valid->pop loop can form.
    assign bus.load_weights_o             = (state == LOAD);
    assign bus.wr_buf_o                   = wr_buf;
    assign bus.rd_buf_o                   = rd_buf;
    assign bus.row_cntr_o                 = row_cntr;
    assign bus.tiles_resident_o           = resident;
    assign bus.compute_weights_rdy_o      = rdy;
    assign bus.compute_weights_buffered_o = buffered;
    assign bus.busy_o                     = busy;
    assign bus.job_done_o                 = job_done;
    assign bus.underflow_o                = underflow;
endmodule

// File: doc/weight_buffer_ctrl.md
# weight_buffer_ctrl

Parametrised weight-tile buffer controller sitting between the weight FIFO and the systolic array weight registers. It loads weight tiles row by row from the FIFO into a ring of NUM_BUFS tile buffers. It tracks how many tiles are resident and tells the compute side when a tile is ready. It generalises fixed double buffering to N-deep buffering and adds a per-instruction tile budget, an end-of-job pulse and underflow detection.

## Interface
- TILE_ROWS, 32: rows per weight tile (= MUL_SIZE); ≥2.
- NUM_BUFS, 2: tile buffers in the ring; 1..8.
- TILE_CNT_W, 16: width of tile budget/counters.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- instruction_i  in  1  start pulse; latches num_tiles_i.
- num_tiles_i  in  TILE_CNT_W  tiles to load for this instruction.
- weight_fifo_valid_output  in  1  FIFO has a row on its output.
- next_weight_tile_i  in  1  compute side releases the current read tile.
- done_i  in  1  abort; return to idle.
- load_weights_o  out  1  pop/shift enable; a row transfers when load_weights_o & weight_fifo_valid_output.
- wr_buf_o  out  $clog2(NUM_BUFS) (min 1)  buffer being written.
- rd_buf_o  out  $clog2(NUM_BUFS) (min 1)  buffer being consumed.
- row_cntr_o  out  $clog2(TILE_ROWS)  row index within current write tile.
- tiles_resident_o  out  $clog2(NUM_BUFS+1)  full tiles held.
- compute_weights_rdy_o  out  1  tiles_resident_o != 0.
- compute_weights_buffered_o  out  1  tiles_resident_o == NUM_BUFS.
- busy_o  out  1  state != IDLE.
- job_done_o  out  1  one-cycle pulse: all budgeted tiles released.
- underflow_o  out  1  sticky: release seen with no resident tile.

## Operation
- States: IDLE, LOAD, WAIT_FULL, DRAIN.
- IDLE: on instruction_i, latch budget = num_tiles_i and clear all counters. Go to LOAD if budget ≠ 0. If budget = 0, pulse job_done_o next cycle and stay in IDLE.
- LOAD: load_weights_o = 1. Each transfer increments row_cntr.
  - On the transfer at row TILE_ROWS-1: row_cntr wraps to 0, wr_buf advances mod NUM_BUFS, tiles_loaded++ and resident++.
  - After tile completion: if tiles_loaded == budget, go to DRAIN; else if resident (post-update) == NUM_BUFS, go to WAIT_FULL; else stay in LOAD.
- WAIT_FULL: load_weights_o = 0. On a release, go to LOAD.
- DRAIN: load_weights_o = 0. When tiles_released reaches budget, pulse job_done_o and go to IDLE.
- Release (any non-IDLE state), when next_weight_tile_i & resident ≠ 0: resident--, rd_buf advances mod NUM_BUFS, tiles_released++.
- Release with resident == 0 (including in IDLE): ignored; underflow_o set. underflow_o clears only on reset or instruction_i.
- A tile completion and a release in the same cycle leave resident unchanged. Both indices advance.
- instruction_i while busy_o: ignored.
- done_i in any state: next cycle go to IDLE, clear all counters, indices and resident. No job_done_o pulse. done_i has priority over every other event.
- Partial tile at abort is discarded.

## Timing
- Reset (rst_i low at an edge): state IDLE and all outputs 0. This includes load_weights_o, wr_buf_o, rd_buf_o, row_cntr_o, tiles_resident_o, job_done_o and underflow_o.
- load_weights_o is combinational from the state register only, never from FIFO valid, so there is no valid→pop loop.
- All other outputs are registered.
- compute_weights_rdy_o and compute_weights_buffered_o rise the cycle after the last-row transfer edge.
- Start latency: instruction_i at edge N → load_weights_o = 1 from cycle N+1.
- Tile load: minimum TILE_ROWS cycles with valid held high. Stalls (valid low) freeze row_cntr_o.
- WAIT_FULL→LOAD: load_weights_o re-asserts the cycle after the release edge.
- job_done_o is asserted for exactly one cycle, the cycle after the final release edge. busy_o falls in that same cycle.
- Counter widths: tiles_loaded and tiles_released are TILE_CNT_W bits. A budget of 2^TILE_CNT_W-1 must complete without wrap.

## Test plan
- NUM_BUFS=2, TILE_ROWS=4, budget 3, valid always high, release 2 cycles after each rdy → 12 transfers; resident seq 1,2,1,2,1,0; wr_buf 0,1,0; job_done_o once; underflow_o=0.
- NUM_BUFS=4, budget 6, no releases → load stops after 16 transfers, WAIT_FULL, buffered=1; release one → exactly 4 more transfers resume next cycle.
- Valid toggling 1/0 each cycle, TILE_ROWS=4 → row_cntr holds on low cycles; tile completes after 8 cycles.
- Last-row transfer coincident with release at resident=1 → resident stays 1, wr_buf and rd_buf both advance.
- done_i mid-tile (row 2) with resident=1 → next cycle IDLE, all outputs 0, no job_done_o; new instruction_i restarts from row 0.
- Budget 0 → job_done_o pulse at N+1, load_weights_o never high. Release with resident=0 → underflow_o=1 and stays 1 until instruction_i.
